// File: rtl/icache_fill.sv
// Line-fill engine for the direct-mapped instruction cache: invalidate, burst-read, write words, commit tag.
// Optional critical-word-first ordering is enabled by defining ICACHE_FILL_CWF_EN.
module icache_fill #(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_req,
  input  logic [31:0]                       miss_addr,
  output logic                              bus_req,
  output logic [31:0]                       bus_addr,
  input  logic                              bus_ack,
  input  logic                              bus_rvalid,
  input  logic [31:0]                       bus_rdata,
  output logic                              fill_we,
  output logic [INDEX_BITS-1:0]             fill_idx,
  output logic [WORD_BITS-1:0]              fill_word,
  output logic [31:0]                       fill_data,
  output logic                              tag_we,
  output logic [29-INDEX_BITS-WORD_BITS:0]  tag_data,
  output logic                              valid_data,
  output logic                              busy
);

  typedef enum logic [2:0] {
    IDLE,
    INVAL,
    REQ,
    DATA,
    COMMIT
  } state_e;

  state_e                             state_q, state_d;
  logic [INDEX_BITS-1:0]              idx_q, idx_d;
  logic [29-INDEX_BITS-WORD_BITS:0]   tag_q, tag_d;
  logic [WORD_BITS-1:0]               startWord_q, startWord_d;
  logic [31:0]                        busAddr_q, busAddr_d;
  logic [WORD_BITS:0]                 beatCnt_q, beatCnt_d;
  logic                               fillWe_q, fillWe_d;
  logic [WORD_BITS-1:0]               fillWord_q, fillWord_d;
  logic [31:0]                        fillData_q, fillData_d;

  logic unused_addrBits;
  assign unused_addrBits = ^miss_addr[WORD_BITS+1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tag_q       <= '0;
      startWord_q <= '0;
      busAddr_q   <= '0;
      beatCnt_q   <= '0;
      fillWe_q    <= 1'b0;
      fillWord_q  <= '0;
      fillData_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      startWord_q <= startWord_d;
      busAddr_q   <= busAddr_d;
      beatCnt_q   <= beatCnt_d;
      fillWe_q    <= fillWe_d;
      fillWord_q  <= fillWord_d;
      fillData_q  <= fillData_d;
    end
  end

  // beatCnt_q reaching 2^WORD_BITS means every beat has been captured; the
  // final registered write is on the outputs in that same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    startWord_d = startWord_q;
    busAddr_d   = busAddr_q;
    beatCnt_d   = beatCnt_q;
    fillWe_d    = 1'b0;
    fillWord_d  = fillWord_q;
    fillData_d  = fillData_q;
    bus_req     = 1'b0;
    tag_we      = 1'b0;
    valid_data  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          idx_d     = miss_addr[WORD_BITS+INDEX_BITS+1:WORD_BITS+2];
          tag_d     = miss_addr[31:WORD_BITS+INDEX_BITS+2];
          beatCnt_d = '0;
`ifdef ICACHE_FILL_CWF_EN
          startWord_d = miss_addr[WORD_BITS+1:2];
          busAddr_d   = {miss_addr[31:2], 2'b00};
`else
          startWord_d = '0;
          busAddr_d   = {miss_addr[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
`endif
          state_d = INVAL;
        end
      end
      INVAL: begin
        tag_we  = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (beatCnt_q[WORD_BITS]) begin
          state_d = COMMIT;
        end else if (bus_rvalid) begin
          fillWe_d   = 1'b1;
          fillWord_d = startWord_q + beatCnt_q[WORD_BITS-1:0];
          fillData_d = bus_rdata;
          beatCnt_d  = beatCnt_q + (WORD_BITS+1)'(1);
        end
      end
      COMMIT: begin
        tag_we     = 1'b1;
        valid_data = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign bus_addr  = (state_q == REQ) ? busAddr_q : '0;
  assign fill_we   = fillWe_q;
  assign fill_idx  = idx_q;
  assign fill_word = fillWord_q;
  assign fill_data = fillData_q;
  assign tag_data  = tag_q;

endmodule

// File: tb/tb_icache_fill.sv
// Directed self-checking bench for icache_fill; expectations follow ICACHE_FILL_CWF_EN when defined.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        fill_we;
  logic [3:0]  fill_idx;
  logic [3:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [21:0] tag_data;
  logic        valid_data;
  logic        busy;

  always #5 clk = ~clk;

  icache_fill dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .fill_we    (fill_we),
    .fill_idx   (fill_idx),
    .fill_word  (fill_word),
    .fill_data  (fill_data),
    .tag_we     (tag_we),
    .tag_data   (tag_data),
    .valid_data (valid_data),
    .busy       (busy)
  );

  int checks = 0;
  int passes = 0;
  int wrCount = 0;
  int invCount = 0;
  int commitCount = 0;
  int overlapCount = 0;
  logic [3:0]  wrIdx  [256];
  logic [3:0]  wrWord [256];
  logic [31:0] wrData [256];

  // Passive log of every array write seen by the cache.
  always @(negedge clk) begin
    if (fill_we) begin
      wrIdx[wrCount[7:0]]  = fill_idx;
      wrWord[wrCount[7:0]] = fill_word;
      wrData[wrCount[7:0]] = fill_data;
      wrCount++;
    end
    if (tag_we && !valid_data) invCount++;
    if (tag_we && valid_data) commitCount++;
    if (tag_we && fill_we) overlapCount++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else
      passes++;
  endtask

  function automatic logic [3:0] expWord(input logic [31:0] addr, input int k);
`ifdef ICACHE_FILL_CWF_EN
    return 4'(addr[5:2] + 4'(k));
`else
    return 4'(k);
`endif
  endfunction

  function automatic logic [31:0] expBusAddr(input logic [31:0] addr);
`ifdef ICACHE_FILL_CWF_EN
    return {addr[31:2], 2'b00};
`else
    return {addr[31:6], 6'b0};
`endif
  endfunction

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_bus_req"},    32'(bus_req),    32'h0);
    checkOutput({tag, "_bus_addr"},   bus_addr,        32'h0);
    checkOutput({tag, "_fill_we"},    32'(fill_we),    32'h0);
    checkOutput({tag, "_fill_idx"},   32'(fill_idx),   32'h0);
    checkOutput({tag, "_fill_word"},  32'(fill_word),  32'h0);
    checkOutput({tag, "_fill_data"},  fill_data,       32'h0);
    checkOutput({tag, "_tag_we"},     32'(tag_we),     32'h0);
    checkOutput({tag, "_tag_data"},   32'(tag_data),   32'h0);
    checkOutput({tag, "_valid_data"}, 32'(valid_data), 32'h0);
    checkOutput({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] idx, input logic [21:0] tag,
                               input int ackDelay, input bit gaps, input bit holdMiss,
                               input logic [31:0] base);
    int wr0, inv0, cm0, reqCycles;
    wr0 = wrCount;
    inv0 = invCount;
    cm0 = commitCount;
    miss_req = 1'b1;
    miss_addr = addr;
    tick;
    if (!holdMiss) miss_req = 1'b0;
    checkOutput("inval_tag_we", 32'(tag_we), 32'h1);
    checkOutput("inval_valid", 32'(valid_data), 32'h0);
    checkOutput("inval_tag", 32'(tag_data), 32'(tag));
    checkOutput("inval_idx", 32'(fill_idx), 32'(idx));
    checkOutput("inval_busy", 32'(busy), 32'h1);
    checkOutput("inval_no_req", 32'(bus_req), 32'h0);
    tick;
    reqCycles = 0;
    for (int i = 0; i < ackDelay; i++) begin
      if (bus_req) reqCycles++;
      checkOutput("req_addr_stable", bus_addr, expBusAddr(addr));
      tick;
    end
    if (bus_req) reqCycles++;
    checkOutput("req_addr", bus_addr, expBusAddr(addr));
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    checkOutput("req_cycles", 32'(reqCycles), 32'(ackDelay + 1));
    checkOutput("req_drop", 32'(bus_req), 32'h0);
    checkOutput("req_drop_addr", bus_addr, 32'h0);
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        bus_rvalid = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hDEAD_DEAD;
        tick;
        bus_ack = 1'b0;
        if (k > 0) checkOutput("gap_no_write", 32'(fill_we), 32'h0);
      end
      bus_rvalid = 1'b1;
      bus_rdata = base + 32'(k);
      tick;
      checkOutput("beat_write_latency", 32'(fill_we), 32'h1);
    end
    bus_rvalid = 1'b0;
    tick;
    checkOutput("commit_tag_we", 32'(tag_we), 32'h1);
    checkOutput("commit_valid", 32'(valid_data), 32'h1);
    checkOutput("commit_no_fill", 32'(fill_we), 32'h0);
    tick;
    checkOutput("done_busy", 32'(busy), 32'h0);
    checkOutput("write_count", 32'(wrCount - wr0), 32'd16);
    checkOutput("inval_count", 32'(invCount - inv0), 32'd1);
    checkOutput("commit_count", 32'(commitCount - cm0), 32'd1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("wr_idx", 32'(wrIdx[8'(wr0 + k)]), 32'(idx));
      checkOutput("wr_word", 32'(wrWord[8'(wr0 + k)]), 32'(expWord(addr, k)));
      checkOutput("wr_data", wrData[8'(wr0 + k)], base + 32'(k));
    end
  endtask

  initial begin
    int wr0, cm0;
    rst = 1'b1;
    miss_req = 1'b0;
    miss_addr = 32'h0;
    bus_ack = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = 32'h0;
    tick;
    tick;
    checkAllReset("reset");
    rst = 1'b0;
    tick;

    applyStimulus(32'h0000_1234, 4'd8, 22'h4, 0, 1'b0, 1'b0, 32'hA000_0000);
    applyStimulus(32'hDEAD_BEEC, 4'd11, 22'h37AB6F, 5, 1'b0, 1'b0, 32'hB000_0000);
    applyStimulus(32'h0000_0FFC, 4'd15, 22'h3, 1, 1'b1, 1'b0, 32'hC000_0000);

    // Reset after the seventh beat: the pending write lands, then everything clears.
    wr0 = wrCount;
    cm0 = commitCount;
    miss_req = 1'b1;
    miss_addr = 32'hDEAD_BEEC;
    tick;
    miss_req = 1'b0;
    tick;
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus_rvalid = 1'b1;
      bus_rdata = 32'hD000_0000 + 32'(k);
      tick;
    end
    rst = 1'b1;
    bus_rdata = 32'hD000_0007;
    tick;
    rst = 1'b0;
    checkAllReset("midreset");
    for (int k = 8; k < 16; k++) begin
      bus_rdata = 32'hD000_0000 + 32'(k);
      tick;
      checkOutput("late_beat_no_write", 32'(fill_we), 32'h0);
    end
    bus_rvalid = 1'b0;
    tick;
    tick;
    checkOutput("midreset_writes", 32'(wrCount - wr0), 32'd7);
    checkOutput("midreset_no_commit", 32'(commitCount - cm0), 32'd0);
    checkOutput("midreset_idle", 32'(busy), 32'h0);

    // Spurious bus activity while idle.
    wr0 = wrCount;
    bus_rvalid = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hEEEE_EEEE;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("spurious_busy", 32'(busy), 32'h0);
      checkOutput("spurious_req", 32'(bus_req), 32'h0);
      checkOutput("spurious_tag_we", 32'(tag_we), 32'h0);
    end
    bus_rvalid = 1'b0;
    bus_ack = 1'b0;
    tick;
    checkOutput("spurious_writes", 32'(wrCount - wr0), 32'd0);

    // miss_req held high throughout: one fill, then a fresh one only from IDLE.
    applyStimulus(32'h0000_1234, 4'd8, 22'h4, 2, 1'b0, 1'b1, 32'hF000_0000);
    tick;
    miss_req = 1'b0;
    checkOutput("rearm_busy", 32'(busy), 32'h1);
    checkOutput("rearm_inval", 32'(tag_we), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;

    checkOutput("tag_fill_overlap", 32'(overlapCount), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
